// File: rtl/gnr_node_state.sv
// gnr_node_state: per-node multi-channel state bank with update dividers,
// steady-state detection and optional transition counters (GNR_NODE_TRANS_CNT_EN).
module gnr_node_state #(
   parameter int WIDTH    = 1,
   parameter int NCH      = 2,
   parameter int DIVW     = 4,
   parameter int STABLE_N = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  reset_nos,
   input  logic [WIDTH-1:0]      init_state,
   input  logic [NCH*DIVW-1:0]   div,
   input  logic [NCH-1:0]        start_s,
   input  logic [NCH*WIDTH-1:0]  next_s,
   output logic [NCH*WIDTH-1:0]  s,
   output logic [NCH-1:0]        changed,
   output logic [NCH-1:0]        stable,
   output logic                  steady,
   output logic [NCH*16-1:0]     trans_cnt
);

   localparam int SW = $clog2(STABLE_N + 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_N);

   for (genvar i = 0; i < NCH; i++) begin : g_ch
      logic [WIDTH-1:0] s_q;
      logic [DIVW-1:0]  ph_q;
      logic [SW-1:0]    st_q;
      logic [SW-1:0]    st_nx;
      logic             chg_q;
      logic             stb_q;
      logic             strobe;
      logic             upd;
      logic             diff;
      logic [WIDTH-1:0] nxt;

      assign nxt    = next_s[i*WIDTH +: WIDTH];
      assign strobe = start & start_s[i] & ~reset_nos;
      assign upd    = strobe & (ph_q == '0);
      assign diff   = (nxt != s_q);

      // stability counter: clear on change, saturate on no-change updates
      always_comb begin
         st_nx = st_q;
         if (upd) begin
            if (diff)
               st_nx = '0;
            else if (st_q != STAB_MAX)
               st_nx = st_q + 1'b1;
         end
      end

      // channel state, phase divider, change pulse and stable flag
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            s_q   <= '0;
            ph_q  <= '0;
            st_q  <= '0;
            chg_q <= 1'b0;
            stb_q <= 1'b0;
         end else if (reset_nos) begin
            s_q   <= init_state;
            ph_q  <= '0;
            st_q  <= '0;
            chg_q <= 1'b0;
            stb_q <= 1'b0;
         end else begin
            chg_q <= 1'b0;
            st_q  <= st_nx;
            stb_q <= (st_nx == STAB_MAX);
            if (strobe) begin
               if (ph_q == '0) begin
                  s_q   <= nxt;
                  ph_q  <= div[i*DIVW +: DIVW];
                  chg_q <= diff;
               end else begin
                  ph_q <= ph_q - 1'b1;
               end
            end
         end
      end

      assign s[i*WIDTH +: WIDTH] = s_q;
      assign changed[i]          = chg_q;
      assign stable[i]           = stb_q;

`ifdef GNR_NODE_TRANS_CNT_EN
      logic [15:0] tc_q;

      // saturating count of value-changing updates
      always_ff @(posedge clk or posedge rst) begin
         if (rst)
            tc_q <= '0;
         else if (reset_nos)
            tc_q <= '0;
         else if (upd && diff && (tc_q != 16'hFFFF))
            tc_q <= tc_q + 16'd1;
      end

      assign trans_cnt[i*16 +: 16] = tc_q;
`else
      assign trans_cnt[i*16 +: 16] = 16'd0;
`endif
   end

   assign steady = &stable;

endmodule

// File: tb/tb_gnr_node_state.sv
// tb_gnr_node_state: directed + random checks of gnr_node_state
// against a behavioural per-channel model.
module tb_gnr_node_state;

   localparam int W  = 2;
   localparam int N  = 2;
   localparam int D  = 4;
   localparam int SN = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            reset_nos;
   logic [W-1:0]    init_state;
   logic [N*D-1:0]  div;
   logic [N-1:0]    start_s;
   logic [N*W-1:0]  next_s;
   logic [N*W-1:0]  s;
   logic [N-1:0]    changed;
   logic [N-1:0]    stable;
   logic            steady;
   logic [N*16-1:0] trans_cnt;

   int nchk = 0;
   int nerr = 0;

   int ms  [N];
   int mph [N];
   int mst [N];
   int mtc [N];
   bit mchg[N];

   gnr_node_state #(
      .WIDTH(W), .NCH(N), .DIVW(D), .STABLE_N(SN)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .reset_nos(reset_nos),
      .init_state(init_state), .div(div), .start_s(start_s),
      .next_s(next_s), .s(s), .changed(changed), .stable(stable),
      .steady(steady), .trans_cnt(trans_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < N; i++) begin
         ms[i] = 0; mph[i] = 0; mst[i] = 0; mtc[i] = 0; mchg[i] = 0;
      end
   endtask

   // one clock edge of the reference behaviour
   task automatic model_step();
      int nx;
      for (int i = 0; i < N; i++) begin
         nx = int'(next_s[i*W +: W]);
         if (reset_nos) begin
            ms[i] = int'(init_state);
            mph[i] = 0; mst[i] = 0; mtc[i] = 0; mchg[i] = 0;
         end else begin
            mchg[i] = 0;
            if (start && start_s[i]) begin
               if (mph[i] == 0) begin
                  if (nx != ms[i]) begin
                     mchg[i] = 1;
                     mst[i] = 0;
                     if (mtc[i] < 65535) mtc[i]++;
                  end else if (mst[i] < SN) begin
                     mst[i]++;
                  end
                  ms[i] = nx;
                  mph[i] = int'(div[i*D +: D]);
               end else begin
                  mph[i]--;
               end
            end
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [N*W-1:0]  es;
      logic [N-1:0]    ec;
      logic [N-1:0]    eb;
      logic [N*16-1:0] et;
      for (int i = 0; i < N; i++) begin
         es[i*W +: W] = W'(ms[i]);
         ec[i] = mchg[i];
         eb[i] = (mst[i] == SN);
`ifdef GNR_NODE_TRANS_CNT_EN
         et[i*16 +: 16] = 16'(mtc[i]);
`else
         et[i*16 +: 16] = 16'd0;
`endif
      end
      chk({tag, ".s"}, 64'(s), 64'(es));
      chk({tag, ".changed"}, 64'(changed), 64'(ec));
      chk({tag, ".stable"}, 64'(stable), 64'(eb));
      chk({tag, ".steady"}, 64'(steady), 64'(&eb));
      chk({tag, ".trans_cnt"}, 64'(trans_cnt), 64'(et));
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic idle();
      reset_nos = 0;
      start_s   = '0;
   endtask

   initial begin
      rst = 1; start = 0; reset_nos = 0; init_state = '0;
      div = '0; start_s = '0; next_s = '0;
      model_clear();
      #1;
      check_all("reset");
      @(negedge clk); @(negedge clk);
      rst = 0;
      cyc("post_reset");

      // divided schedule: ch0 div=1, ch1 div=0
      start = 1;
      div = {4'd0, 4'd1};
      reset_nos = 1; init_state = 2'd1; start_s = 2'b11;
      cyc("legacy_rnos");
      reset_nos = 0;
      for (int k = 0; k < 4; k++) begin
         next_s = (k % 2 == 0) ? {2'd0, 2'd0} : {2'd1, 2'd1};
         cyc("legacy");
      end
      chk("legacy_ch0", 64'(s[1:0]), 64'd0);
      chk("legacy_ch1", 64'(s[3:2]), 64'd1);

      // stability
      div = '0;
      reset_nos = 1; init_state = 2'd1; start_s = '0;
      cyc("stab_rnos");
      reset_nos = 0;
      start_s = 2'b11; next_s = {2'd1, 2'd1};
      for (int k = 0; k < 4; k++) cyc("stab_hold");
      chk("stab_stable", 64'(stable), 64'd3);
      chk("stab_steady", 64'(steady), 64'd1);
      next_s = {2'd2, 2'd2};
      cyc("stab_change");
      chk("stab_chg", 64'(changed), 64'd3);
      chk("stab_drop", 64'(stable), 64'd0);
      idle();
      cyc("stab_idle");
      chk("stab_chg_end", 64'(changed), 64'd0);

      // reset_nos wins over strobes
      reset_nos = 1; init_state = 2'd1; start_s = 2'b11; next_s = '0;
      cyc("prio");
      chk("prio_s", 64'(s), 64'h5);
      chk("prio_chg", 64'(changed), 64'd0);
      reset_nos = 0;
      cyc("prio_first_upd");
      chk("prio_upd_s", 64'(s), 64'h0);

      // gating by start
      reset_nos = 1; init_state = 2'd0; start_s = '0;
      cyc("gate_rnos");
      reset_nos = 0; start = 0; next_s = {2'd3, 2'd3};
      for (int k = 0; k < 3; k++) begin
         start_s = 2'b11;
         cyc("gate_off");
         start_s = '0;
         cyc("gate_gap");
      end
      chk("gate_hold", 64'(s), 64'h0);
      start = 1; start_s = 2'b11;
      cyc("gate_on");
      chk("gate_upd", 64'(s), 64'hF);

      // transition counter
      div = '0;
      reset_nos = 1; init_state = 2'd0; start_s = '0;
      cyc("tc_rnos");
      reset_nos = 0; start_s = 2'b11;
      for (int k = 0; k < 5; k++) begin
         next_s = (k % 2 == 0) ? {2'd1, 2'd1} : {2'd0, 2'd0};
         cyc("tc_upd");
      end
`ifdef GNR_NODE_TRANS_CNT_EN
      chk("tc_five", 64'(trans_cnt), {32'd0, 16'd5, 16'd5});
`else
      chk("tc_five", 64'(trans_cnt), 64'd0);
`endif
      reset_nos = 1; start_s = '0;
      cyc("tc_clear");
      chk("tc_zero", 64'(trans_cnt), 64'd0);
      reset_nos = 0;

      // random traffic
      for (int k = 0; k < 400; k++) begin
         start      = ($urandom_range(0, 7) != 0);
         reset_nos  = ($urandom_range(0, 29) == 0);
         init_state = W'($urandom);
         start_s    = N'($urandom);
         div        = {D'($urandom_range(0, 3)), D'($urandom_range(0, 3))};
         next_s     = ($urandom_range(0, 2) == 0) ? (N*W)'($urandom) : next_s;
         cyc("rand");
      end

      // asynchronous reset mid-cycle
      idle();
      start = 1; reset_nos = 1; init_state = 2'd3;
      cyc("ar_load");
      chk("ar_s11", 64'(s), 64'hF);
      reset_nos = 0;
      #2;
      rst = 1;
      model_clear();
      #1;
      check_all("ar_async");
      @(negedge clk);
      rst = 0;
      cyc("ar_after");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
